// File: rtl/pulse_stretcher_if.sv
// Bundle of the pulse stretcher's control inputs and status outputs.
// The master side (controller/bench) drives the event and timing controls;
// the slave side (the stretcher) returns the level, markers and drop count.
interface pulse_stretcher_if #(
  parameter int LEN_W  = 16,
  parameter int DROP_W = 8
) ();
  logic              pulse_i;
  logic [LEN_W-1:0]  len_i;
  logic [LEN_W-1:0]  gap_i;
  logic              retrig_i;
  logic              drop_clr_i;
  logic              level_o;
  logic              busy_o;
  logic              rise_o;
  logic              fall_o;
  logic              drop_o;
  logic [DROP_W-1:0] drop_cnt_o;

  modport master (
    output pulse_i, len_i, gap_i, retrig_i, drop_clr_i,
    input  level_o, busy_o, rise_o, fall_o, drop_o, drop_cnt_o
  );

  modport slave (
    input  pulse_i, len_i, gap_i, retrig_i, drop_clr_i,
    output level_o, busy_o, rise_o, fall_o, drop_o, drop_cnt_o
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event pulses into a timed high level
// followed by an optional low hold-off. Pulses that cannot be honoured are
// flagged on drop_o and counted in a saturating counter.
// The counter holds the number of cycles remaining in the current phase,
// including the present one, so a phase ends when it reaches 1.
module pulse_stretcher #(
  parameter int LEN_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  pulse_stretcher_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              reject_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              level_q, busy_q, rise_q, fall_q, drop_q;

  // Next-state, phase counter and pulse-rejection decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.pulse_i) begin
          if (bus.len_i != '0) begin
            state_d = S_HIGH;
            cnt_d   = bus.len_i;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (bus.pulse_i && bus.retrig_i && (bus.len_i != '0)) begin
          // Retrigger wins even on the last high cycle, so no fall occurs.
          cnt_d = bus.len_i;
        end else begin
          reject_d = bus.pulse_i;
          if (cnt_q <= LEN_W'(1)) begin
            if (bus.gap_i != '0) begin
              state_d = S_GAP;
              cnt_d   = bus.gap_i;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        reject_d = bus.pulse_i;
        if (cnt_q <= LEN_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Drop counter: clear has priority over a same-cycle rejection; saturates.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.drop_clr_i) begin
      drop_cnt_d = '0;
    end else if (reject_d && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= (state_d == S_HIGH);
      busy_q     <= (state_d != S_IDLE);
      rise_q     <= (state_d == S_HIGH) && (state_q != S_HIGH);
      fall_q     <= (state_q == S_HIGH) && (state_d != S_HIGH);
      drop_q     <= reject_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.level_o    = level_q;
  assign bus.busy_o     = busy_q;
  assign bus.rise_o     = rise_q;
  assign bus.fall_o     = fall_q;
  assign bus.drop_o     = drop_q;
  assign bus.drop_cnt_o = drop_cnt_q;

endmodule
